// File: rtl/gpr_write_ctrl.sv
// Write-port controller for the general purpose register file: clears registers
// 1..NREG-1 after reset, then round-robin arbitrates ALU and load writebacks.
`timescale 1ns/1ps

module gpr_write_ctrl #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic [DW-1:0] gpr_sin,
    output logic [AW-1:0] gpr_sc,
    output logic          gpr_sw,
    output logic          init_done
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [AW-1:0] FIRST_IDX = AW'(1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          rr_pri_q, rr_pri_d;
    logic          init_done_q, init_done_d;
    logic          gpr_sw_q, gpr_sw_d;
    logic [AW-1:0] gpr_sc_q, gpr_sc_d;
    logic [DW-1:0] gpr_sin_q, gpr_sin_d;

    logic          alu_grant;
    logic          mem_grant;

    // rr_pri == 0 favours the ALU, 1 favours the load path; a lone requester
    // is always ready so it never waits on an idle competitor.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves a value unassigned and no latch is inferred.
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (state_q == ST_RUN) begin
            alu_ready = !mem_valid || !rr_pri_q;
            mem_ready = !alu_valid ||  rr_pri_q;
        end
        alu_grant = alu_valid && alu_ready;
        mem_grant = mem_valid && mem_ready;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rr_pri_d    = rr_pri_q;
        init_done_d = init_done_q;
        gpr_sw_d    = 1'b0;
        gpr_sc_d    = gpr_sc_q;
        gpr_sin_d   = gpr_sin_q;

        unique case (state_q)
            ST_CLEAR: begin
                gpr_sw_d  = 1'b1;
                gpr_sc_d  = idx_q;
                gpr_sin_d = '0;
                idx_d     = idx_q + FIRST_IDX;
                if (idx_q == LAST_IDX) begin
                    init_done_d = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                // Register 0 is hardwired zero: the handshake completes but
                // the write enable stays low.
                if (alu_grant) begin
                    gpr_sc_d  = alu_addr;
                    gpr_sin_d = alu_data;
                    gpr_sw_d  = (alu_addr != '0);
                    rr_pri_d  = 1'b1;
                end else if (mem_grant) begin
                    gpr_sc_d  = mem_addr;
                    gpr_sin_d = mem_data;
                    gpr_sw_d  = (mem_addr != '0);
                    rr_pri_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            idx_q       <= FIRST_IDX;
            rr_pri_q    <= 1'b0;
            init_done_q <= 1'b0;
            gpr_sw_q    <= 1'b0;
            gpr_sc_q    <= '0;
            gpr_sin_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_pri_q    <= rr_pri_d;
            init_done_q <= init_done_d;
            gpr_sw_q    <= gpr_sw_d;
            gpr_sc_q    <= gpr_sc_d;
            gpr_sin_q   <= gpr_sin_d;
        end
    end

    assign gpr_sw    = gpr_sw_q;
    assign gpr_sc    = gpr_sc_q;
    assign gpr_sin   = gpr_sin_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_gpr_write_ctrl.sv
// Self-checking bench for gpr_write_ctrl: expected register-file writes are
// queued when a grant is predicted and compared when gpr_sw is observed.
`timescale 1ns/1ps

module tb_gpr_write_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_addr = '0;
    logic [DW-1:0] alu_data = '0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] gpr_sin;
    logic [AW-1:0] gpr_sc;
    logic          gpr_sw;
    logic          init_done;

    int n_checks = 0;
    int n_fail   = 0;

    wr_t exp_q[$];
    wr_t mon_e;

    // Requester model
    logic          a_pend = 1'b0, m_pend = 1'b0;
    logic [AW-1:0] a_addr = '0, m_addr = '0;
    logic [DW-1:0] a_data = '0, m_data = '0;
    logic          rr_m = 1'b0;
    logic          dut_ga, dut_gm;

    gpr_write_ctrl #(.DW(DW), .AW(AW), .NREG(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .gpr_sin   (gpr_sin),
        .gpr_sc    (gpr_sc),
        .gpr_sw    (gpr_sw),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every edge out of reset either retires exactly one
    // queued write or must show the write enable low.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_sw", 32'(gpr_sw), 32'd1);
                check("wr_sc", 32'(gpr_sc), 32'(mon_e.addr));
                check("wr_sin", gpr_sin, mon_e.data);
            end else begin
                check("idle_sw", 32'(gpr_sw), 32'd0);
            end
        end
    end

    // One cycle of arbitration: drive pending requests, check ready against
    // the round-robin model, and queue the write the grant should produce.
    task automatic step();
        logic exp_ar, exp_mr;
        @(negedge clk);
        alu_valid = a_pend; alu_addr = a_addr; alu_data = a_data;
        mem_valid = m_pend; mem_addr = m_addr; mem_data = m_data;
        #1;
        exp_ar = !m_pend || !rr_m;
        exp_mr = !a_pend ||  rr_m;
        check("alu_ready", 32'(alu_ready), 32'(exp_ar));
        check("mem_ready", 32'(mem_ready), 32'(exp_mr));
        dut_ga = alu_valid && alu_ready;
        dut_gm = mem_valid && mem_ready;
        if (a_pend && exp_ar) begin
            if (a_addr != '0) exp_q.push_back({a_addr, a_data});
            rr_m   = 1'b1;
            a_pend = 1'b0;
        end else if (m_pend && exp_mr) begin
            if (m_addr != '0) exp_q.push_back({m_addr, m_data});
            rr_m   = 1'b0;
            m_pend = 1'b0;
        end
    endtask

    task automatic drain();
        int budget = 0;
        while ((a_pend || m_pend) && budget < 20) begin
            step();
            budget++;
        end
        check("drain_budget", 32'(a_pend || m_pend), 32'd0);
        step();
    endtask

    task automatic run_clear(input logic hold_valid);
        for (int k = 1; k <= 31; k++) begin
            exp_q.push_back({AW'(k), DW'(0)});
            alu_valid = hold_valid;
            mem_valid = hold_valid;
            #1;
            check("clr_alu_ready", 32'(alu_ready), 32'd0);
            check("clr_mem_ready", 32'(mem_ready), 32'd0);
            @(negedge clk);
            check("clr_init_done", 32'(init_done), 32'(k == 31));
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic reset_dut(input logic hold_valid);
        @(negedge clk);
        rst_n = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;
        a_pend = 1'b0; m_pend = 1'b0;
        rr_m = 1'b0;
        exp_q.delete();
        #1;
        check("rst_sw", 32'(gpr_sw), 32'd0);
        check("rst_sc", 32'(gpr_sc), 32'd0);
        check("rst_sin", gpr_sin, 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_clear(hold_valid);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_dut(1'b0);
        step();

        // Single ALU write
        a_pend = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        step();
        check("alu_single_grant", 32'(dut_ga), 32'd1);
        step();
        step();

        // Load to register 0: handshake, no write; also returns priority to ALU
        m_pend = 1'b1; m_addr = 5'd0; m_data = 32'hFFFFFFFF;
        step();
        check("mem_r0_grant", 32'(dut_gm), 32'd1);
        step();
        check("mem_r0_no_sw", 32'(gpr_sw), 32'd0);

        // Same-address collision: ALU first, load second, load data persists
        a_pend = 1'b1; a_addr = 5'd3; a_data = 32'h11;
        m_pend = 1'b1; m_addr = 5'd3; m_data = 32'h22;
        step();
        check("both_first_alu", 32'(dut_ga), 32'd1);
        step();
        check("both_second_mem", 32'(dut_gm), 32'd1);
        step();
        check("both_final_sc", 32'(gpr_sc), 32'd3);
        check("both_final_sin", gpr_sin, 32'h22);

        // Continuous contention: grants alternate A,M,A,M,A,M
        for (int i = 0; i < 6; i++) begin
            if (!a_pend) begin
                a_pend = 1'b1; a_addr = AW'(10 + i); a_data = 32'hA000_0000 + 32'(i);
            end
            if (!m_pend) begin
                m_pend = 1'b1; m_addr = AW'(20 + i); m_data = 32'hB000_0000 + 32'(i);
            end
            step();
            check("alt_grant_alu", 32'(dut_ga), 32'(i % 2 == 0));
            check("alt_grant_mem", 32'(dut_gm), 32'(i % 2 == 1));
        end
        drain();

        // Reset in the cycle after an ALU handshake drops the pending write
        a_pend = 1'b1; a_addr = 5'd7; a_data = 32'h12345678;
        step();
        check("prerst_grant", 32'(dut_ga), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        alu_valid = 1'b0;
        #1;
        check("midrst_sw", 32'(gpr_sw), 32'd0);
        check("midrst_init_done", 32'(init_done), 32'd0);
        reset_dut(1'b1);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
